// File: rtl/rv32i_pkg.sv
// Types and constants shared by the rv32i core front end (fetch) and the ALU.
// RV32I_FETCH_MISALIGN_TRAP_EN adds the S_HALT fetch state.
package rv32i_pkg;

    localparam int ILEN_BYTES_DFLT = 4;

    typedef enum logic [1:0] {
        BRANCH_NONE     = 2'd0,
        BRANCH_RELATIVE = 2'd1,
        BRANCH_ABSOLUTE = 2'd2
    } branch_type_e;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        ,
        S_HALT  = 3'd4
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC mux: sequential, pc-relative or absolute target; unknown branch encodings fall back to sequential.
// Latency: purely combinational. Backpressure: none.
// Flow control: none; the caller decides when the result is used.
module next_pc_sel
    import rv32i_pkg::*;
#(
    parameter int ILEN_BYTES = ILEN_BYTES_DFLT
) (
    input  branch_type_e branch_type,
    input  logic [31:0]  pc,
    input  logic [31:0]  branch_imm,
    input  logic [31:0]  alu_result,
    output logic [31:0]  next_pc
);

    always_comb begin
        next_pc = pc + 32'(ILEN_BYTES);
        case (branch_type)
            BRANCH_RELATIVE: next_pc = pc + branch_imm;
            BRANCH_ABSOLUTE: next_pc = alu_result;
            default:         next_pc = pc + 32'(ILEN_BYTES);
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC sequencer, one instruction in flight; RV32I_FETCH_MISALIGN_TRAP_EN halts on a misaligned target.
// Latency: 4 cycles per instruction minimum (REQ, WAIT, ISSUE, EXEC) with zero-wait memory.
// Backpressure: request held until imem_ready, instruction held until inst_ready, EXEC waits for exec_done.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          ILEN_BYTES = ILEN_BYTES_DFLT
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic         inst_valid,
    output logic [31:0]  inst_data,
    output logic [31:0]  inst_pc,
    input  logic         inst_ready,
    input  logic         exec_done,
    input  branch_type_e branch_type,
    input  logic [31:0]  branch_imm,
    input  logic [31:0]  alu_result,
    output logic [31:0]  pc_plus4
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    ,
    output logic         fetch_misaligned
`endif
);

    fetch_state_e state, state_next;
    logic [31:0]  pc;
    logic [31:0]  sel_pc;
    logic [31:0]  target_pc;
    logic         target_misaligned;

    next_pc_sel #(.ILEN_BYTES(ILEN_BYTES)) u_next_pc_sel (
        .branch_type (branch_type),
        .pc          (pc),
        .branch_imm  (branch_imm),
        .alu_result  (alu_result),
        .next_pc     (sel_pc)
    );

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    assign target_pc         = sel_pc;
    assign target_misaligned = |sel_pc[1:0];
`else
    // Without the trap, a misaligned target is silently word-aligned.
    assign target_pc         = sel_pc & ~32'h3;
    assign target_misaligned = 1'b0;
`endif

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~reset;
                if (imem_ready) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                inst_valid = 1'b1;
                if (inst_ready) state_next = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
                    state_next = target_misaligned ? S_HALT : S_REQ;
`else
                    state_next = S_REQ;
`endif
                end
            end
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst_data <= 32'h0;
            inst_pc   <= RESET_PC;
        end else begin
            state <= state_next;
            if (state == S_WAIT && imem_rvalid) begin
                inst_data <= imem_rdata;
                inst_pc   <= pc;
            end
            if (state == S_EXEC && exec_done) pc <= target_pc;
        end
    end

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         fetch_misaligned <= 1'b0;
        else if (state == S_EXEC && exec_done && target_misaligned) fetch_misaligned <= 1'b1;
    end
`else
    logic unused_misaligned;
    assign unused_misaligned = target_misaligned;
`endif

    assign imem_addr = pc;
    assign pc_plus4  = inst_pc + 32'(ILEN_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomized handshake timing checked against a PC-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic         clk = 1'b0;
    logic         reset;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         inst_valid;
    logic [31:0]  inst_data;
    logic [31:0]  inst_pc;
    logic         inst_ready;
    logic         exec_done;
    branch_type_e branch_type;
    logic [31:0]  branch_imm;
    logic [31:0]  alu_result;
    logic [31:0]  pc_plus4;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
    logic         fetch_misaligned;
`endif

    fetch_unit #(.RESET_PC(RST_PC), .ILEN_BYTES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .exec_done   (exec_done),
        .branch_type (branch_type),
        .branch_imm  (branch_imm),
        .alu_result  (alu_result),
        .pc_plus4    (pc_plus4)
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int          cyc        = 0;
    logic [31:0] model_pc;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory never returns data in the same cycle it accepts a request.
    always @(negedge clk) begin
        if (reset === 1'b0)
            assert (!(imem_ready === 1'b1 && imem_rvalid === 1'b1))
            else $error("illegal stimulus: imem_ready and imem_rvalid together");
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_next(input logic [31:0] pc, input branch_type_e bt,
                                             input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] t;
        if (bt == BRANCH_RELATIVE)      t = pc + imm;
        else if (bt == BRANCH_ABSOLUTE) t = alu;
        else                            t = pc + 32'd4;
`ifndef RV32I_FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        return t;
    endfunction

    // One complete fetch/issue/execute round with the given handshake delays.
    task automatic run_instr(input int rd, input int rv, input int ir, input int ed,
                             input branch_type_e bt, input logic [31:0] imm, input logic [31:0] alu,
                             output int issue_cyc);
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k < 20 && imem_req !== 1'b1; k++) @(negedge clk);
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, model_pc}) begin
            miscompares++;
            $display("FAIL fetch_req: req=%b addr=%h, need req=1 addr=%h", imem_req, imem_addr, model_pc);
        end
        for (int k = 0; k < rd; k++) begin
            imem_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if ({imem_req, imem_addr} !== {1'b1, model_pc}) begin
                miscompares++;
                $display("FAIL req_hold: req=%b addr=%h, need req=1 addr=%h", imem_req, imem_addr, model_pc);
            end
        end
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_req: req=%b, need 0", imem_req);
        end
        for (int k = 1; k < rv; k++) begin
            exec_done   = 1'($urandom);
            branch_type = BRANCH_ABSOLUTE;
            alu_result  = $urandom;
            @(negedge clk);
        end
        exec_done   = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        issue_cyc   = cyc;
        for (int k = 0; k <= ir; k++) begin
            vectors++;
            if ({inst_valid, inst_data, inst_pc, pc_plus4} !== {1'b1, word, model_pc, model_pc + 32'd4}) begin
                miscompares++;
                $display("FAIL issue: valid=%b data=%h pc=%h p4=%h, need 1 %h %h %h",
                         inst_valid, inst_data, inst_pc, pc_plus4, word, model_pc, model_pc + 32'd4);
            end
            inst_ready = (k == ir);
            if (k != ir) @(negedge clk);
        end
        @(negedge clk);
        inst_ready = 1'b0;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL exec_valid: inst_valid=%b, need 0", inst_valid);
        end
        repeat (ed) @(negedge clk);
        exec_done   = 1'b1;
        branch_type = bt;
        branch_imm  = imm;
        alu_result  = alu;
        @(negedge clk);
        exec_done   = 1'b0;
        branch_type = BRANCH_NONE;
        model_pc    = ref_next(model_pc, bt, imm, alu);
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; exec_done = 1'b0; branch_type = BRANCH_NONE;
        branch_imm = 32'h0; alu_result = 32'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({imem_req, inst_valid, inst_data, imem_addr} !== {1'b0, 1'b0, 32'h0, RST_PC}) begin
            miscompares++;
            $display("FAIL reset_state: req=%b valid=%b data=%h addr=%h, need 0 0 0 %h",
                     imem_req, inst_valid, inst_data, imem_addr, RST_PC);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
            miscompares++;
            $display("FAIL reset_release: req=%b addr=%h, need 1 %h", imem_req, imem_addr, RST_PC);
        end
        model_pc = RST_PC;
    endtask

    task automatic test_sequential();
        int c0, c1, c2;
        run_instr(0, 1, 0, 0, BRANCH_NONE, 32'h0, 32'h0, c0);
        run_instr(0, 1, 0, 0, BRANCH_NONE, 32'h0, 32'h0, c1);
        run_instr(0, 1, 0, 0, BRANCH_NONE, 32'h0, 32'h0, c2);
        vectors++;
        if (c1 - c0 !== 4 || c2 - c1 !== 4) begin
            miscompares++;
            $display("FAIL throughput: gaps %0d %0d cycles, need 4 4", c1 - c0, c2 - c1);
        end
        #1;
        vectors++;
        if (imem_addr !== 32'h10C) begin
            miscompares++;
            $display("FAIL seq_addr: addr=%h, need 0000010c", imem_addr);
        end
    endtask

    task automatic test_branches();
        int c;
        run_instr(0, 1, 0, 0, BRANCH_ABSOLUTE, 32'h0, 32'h0000_0200, c);
        run_instr(0, 1, 0, 0, BRANCH_RELATIVE, 32'hFFFF_FFF0, 32'h0, c);
        #1;
        vectors++;
        if (imem_addr !== 32'h1F0) begin
            miscompares++;
            $display("FAIL relative: addr=%h, need 000001f0", imem_addr);
        end
        run_instr(0, 1, 0, 0, BRANCH_ABSOLUTE, 32'h0, 32'h0000_3000, c);
        #1;
        vectors++;
        if (imem_addr !== 32'h3000) begin
            miscompares++;
            $display("FAIL absolute: addr=%h, need 00003000", imem_addr);
        end
        run_instr(0, 1, 0, 0, branch_type_e'(2'd3), 32'h40, 32'h8000, c);
        #1;
        vectors++;
        if (imem_addr !== 32'h3004) begin
            miscompares++;
            $display("FAIL bad_encoding: addr=%h, need 00003004", imem_addr);
        end
    endtask

    task automatic test_stall();
        int c;
        run_instr(3, 5, 2, 3, BRANCH_NONE, 32'h0, 32'h0, c);
    endtask

    task automatic test_wrap();
        int c;
        run_instr(0, 1, 0, 0, BRANCH_ABSOLUTE, 32'h0, 32'hFFFF_FFFC, c);
        run_instr(1, 2, 0, 1, BRANCH_NONE, 32'h0, 32'h0, c);
        #1;
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap: addr=%h, need 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        int c;
        for (int k = 0; k < 20 && imem_req !== 1'b1; k++) @(negedge clk);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if ({imem_req, inst_valid, imem_addr} !== {1'b0, 1'b0, RST_PC}) begin
            miscompares++;
            $display("FAIL reset_wait: req=%b valid=%b addr=%h, need 0 0 %h",
                     imem_req, inst_valid, imem_addr, RST_PC);
        end
        @(negedge clk);
        reset = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        vectors++;
        if ({imem_req, inst_valid, imem_addr} !== {1'b1, 1'b0, RST_PC} || inst_data === 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL stale_rvalid: req=%b valid=%b addr=%h data=%h, need 1 0 %h and no stale data",
                     imem_req, inst_valid, imem_addr, inst_data, RST_PC);
        end
        model_pc = RST_PC;
        run_instr(0, 1, 0, 0, BRANCH_NONE, 32'h0, 32'h0, c);
    endtask

    task automatic test_misalign();
        int c;
        run_instr(0, 1, 0, 0, BRANCH_ABSOLUTE, 32'h0, 32'h0000_1002, c);
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({fetch_misaligned, imem_req, imem_addr} !== {1'b1, 1'b0, 32'h1002}) begin
                miscompares++;
                $display("FAIL halt: misaligned=%b req=%b addr=%h, need 1 0 00001002",
                         fetch_misaligned, imem_req, imem_addr);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({fetch_misaligned, imem_req, imem_addr} !== {1'b0, 1'b1, RST_PC}) begin
            miscompares++;
            $display("FAIL halt_clear: misaligned=%b req=%b addr=%h, need 0 1 %h",
                     fetch_misaligned, imem_req, imem_addr, RST_PC);
        end
        model_pc = RST_PC;
`else
        #1;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h1000}) begin
            miscompares++;
            $display("FAIL misalign_mask: req=%b addr=%h, need 1 00001000", imem_req, imem_addr);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int c;
        branch_type_e bt;
        logic [31:0] imm, alu;
        for (int n = 0; n < 40; n++) begin
            bt  = branch_type_e'(2'($urandom_range(0, 3)));
            imm = $urandom;
            alu = $urandom;
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
            imm = imm & ~32'h3;
            alu = alu & ~32'h3;
`endif
            run_instr($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 2),
                      $urandom_range(0, 3), bt, imm, alu, c);
        end
        run_instr(0, 1, 0, 0, BRANCH_NONE, 32'h0, 32'h0, c);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_stall();
        test_wrap();
        test_reset_in_wait();
        test_misalign();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC sequencing stage that sits directly upstream of the ALU in the multi-cycle rv32i core.
- Owns the architectural PC and issues one instruction-memory read at a time.
- Hands each fetched word to decode/execute, then consumes the ALU's branch_type and result to choose the next PC.
- Strictly one instruction in flight: no prefetch, no speculation.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ILEN_BYTES, 4, PC increment for sequential flow.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  byte address of the request; equals the PC.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  fetched instruction available to decode.
- inst_data  out  32  the instruction word.
- inst_pc  out  32  PC of inst_data.
- inst_ready  in  1  decode accepts the instruction.
- exec_done  in  1  execute finished; the branch inputs are valid this cycle.
- branch_type  in  branch_type_e  BRANCH_NONE, BRANCH_RELATIVE or BRANCH_ABSOLUTE, from the ALU.
- branch_imm  in  32  sign-extended B/J immediate, from decode.
- alu_result  in  32  ALU result; the JALR target, already LSB-cleared.
- pc_plus4  out  32  inst_pc + ILEN_BYTES, used as the JAL/JALR link value.

Behaviour:
- Reset (asynchronous, active-high):
  - state = S_REQ, pc = RESET_PC.
  - inst_valid = 0, inst_data = 0, imem_req = 0 while reset is asserted.
  - Reset mid-transaction discards any outstanding read. An imem_rvalid arriving after reset deasserts is ignored unless the state is S_WAIT.
- State S_REQ:
  - imem_req = 1, imem_addr = pc.
  - imem_ready = 1 -> S_WAIT.
  - Request and address are held stable until accepted.
- State S_WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 -> capture imem_rdata into inst_data, set inst_pc = pc, go to S_ISSUE.
  - A same-cycle ready and rvalid in S_REQ is illegal (rvalid always lags by at least one cycle); the bench asserts on it.
- State S_ISSUE:
  - inst_valid = 1; inst_data and inst_pc are stable.
  - inst_ready = 1 -> inst_valid drops next cycle, go to S_EXEC.
- State S_EXEC:
  - Wait for exec_done. On exec_done, next_pc is:
    - BRANCH_NONE -> pc + ILEN_BYTES
    - BRANCH_RELATIVE -> pc + branch_imm
    - BRANCH_ABSOLUTE -> alu_result
  - The selected value is registered into pc and the state returns to S_REQ.
  - Any other branch_type encoding is treated as BRANCH_NONE.
- Arithmetic: all PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is silent.
- Throughput: the minimum loop is 4 cycles per instruction (REQ, WAIT, ISSUE, EXEC) with zero-wait memory and immediate ready/done.
- pc_plus4 is combinational from inst_pc.
- exec_done outside S_EXEC is ignored.

Optional Feature:
- Macro RV32I_FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - If the selected next_pc[1:0] != 0 in S_EXEC, pc still loads the target, fetch_misaligned becomes 1 and sticky, and the FSM enters S_HALT (no further requests).
  - Only reset clears S_HALT.
- When undefined: next_pc[1:0] is forced to 2'b00 and no halt state exists.

Decomposition:
- Package rv32i (shared with the ALU): branch_type_e, the fetch state enum fetch_state_e, and the constant ILEN_BYTES default.
- Sub-module next_pc_sel (combinational): branch_type, pc, branch_imm, alu_result -> next_pc. It is reused by any later pipelined fetch.

Test Plan:
- Reset with RESET_PC = 32'h100, zero-wait memory, all branches NONE -> imem_addr sequence 0x100, 0x104, 0x108; one inst_valid pulse per 4 cycles.
- In S_EXEC with pc = 0x200, BRANCH_RELATIVE, branch_imm = 32'hFFFF_FFF0 -> next imem_addr = 0x1F0.
- BRANCH_ABSOLUTE with alu_result = 0x0000_3000 -> next imem_addr = 0x3000; pc_plus4 during the issue was inst_pc + 4.
- imem_ready low for 3 cycles, then rvalid after 5 cycles -> imem_addr is stable throughout; inst_data equals the returned word; inst_ready held low for 2 cycles keeps inst_valid and inst_data stable.
- Reset asserted in S_WAIT, then a stale rvalid -> the FSM is in S_REQ at RESET_PC; the stale data is never presented on inst_data.
- With RV32I_FETCH_MISALIGN_TRAP_EN, BRANCH_ABSOLUTE to 0x1002 -> fetch_misaligned = 1 and imem_req stays 0. Without the macro, the next imem_addr = 0x1000.
